// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target endpoint: START/STOP decode, 7-bit address match, byte read/write handshake
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       rw,
  output logic       busy,
  output logic       stop_det,
  input  logic       scl,
  inout  wire        sda
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_h_q, sda_h_q;
  state_t                 state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   ack_phase_q, ack_phase_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   rw_q, rw_d;
  logic                   busy_q, busy_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   tx_load_q, tx_load_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   addr_match_q, addr_match_d;
  logic                   stop_det_q, stop_det_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_h_q;
  assign scl_fall = ~scl_s & scl_h_q;
  // SCL must be stable high across the history window for a bus condition
  assign start_ev = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_ev  = scl_s & scl_h_q & ~sda_h_q & sda_s;

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_load    = tx_load_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_match = addr_match_q;
  assign rw         = rw_q;
  assign busy       = busy_q;
  assign stop_det   = stop_det_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_h_q      <= 1'b1;
      sda_h_q      <= 1'b1;
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      ack_phase_q  <= 1'b0;
      sda_oe_q     <= 1'b0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      rx_data_q    <= 8'h00;
      tx_load_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      stop_det_q   <= 1'b0;
    end else begin
      scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_h_q      <= scl_s;
      sda_h_q      <= sda_s;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ack_phase_q  <= ack_phase_d;
      sda_oe_q     <= sda_oe_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      rx_data_q    <= rx_data_d;
      tx_load_q    <= tx_load_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      stop_det_q   <= stop_det_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ack_phase_d  = ack_phase_q;
    sda_oe_d     = sda_oe_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    rx_data_d    = rx_data_q;
    tx_load_d    = 1'b0;
    rx_valid_d   = 1'b0;
    addr_match_d = 1'b0;
    stop_det_d   = 1'b0;

    if (!enable) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_ev) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_q[6:0] == SLAVE_ADDR) begin
              rw_d        = sda_s;
              ack_phase_d = 1'b0;
              state_d     = ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d     = 1'b1;
            addr_match_d = 1'b1;
            busy_d       = 1'b1;
            ack_phase_d  = 1'b1;
          end else begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              shift_d   = tx_data;
              tx_load_d = 1'b1;
              sda_oe_d  = ~tx_data[7];
              state_d   = READ;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WRITE;
            end
          end
        end
        WRITE: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d   = {shift_q[6:0], sda_s};
            rx_valid_d  = 1'b1;
            ack_phase_d = 1'b0;
            state_d     = WRITE_ACK;
          end
        end
        WRITE_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d    = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = WRITE;
          end
        end
        // bit_cnt counts master sample edges; wrapping to 0 marks the byte done
        READ: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b0;
              state_d     = READ_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              ack_phase_d = 1'b1;
            end
          end else if (scl_fall && ack_phase_q) begin
            shift_d   = tx_data;
            tx_load_d = 1'b1;
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = 3'd0;
            state_d   = READ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bench for i2c_slave with a bit-banged bus master
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load, rx_valid, addr_match, rw, busy, stop_det;
  logic [7:0] rx_data;
  logic       scl_m = 1'b1;
  logic       m_oe = 1'b0;
  wire        sda_bus;

  assign sda_bus = m_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave #(.SLAVE_ADDR(7'h48), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tx_data(tx_data),
    .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr_match(addr_match), .rw(rw), .busy(busy), .stop_det(stop_det),
    .scl(scl_m), .sda(sda_bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_am = 0, n_rx = 0, n_tx = 0, n_stop = 0, n_drive = 0;
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    if (addr_match) n_am++;
    if (rx_valid) begin
      n_rx++;
      last_rx = rx_data;
    end
    if (tx_load) n_tx++;
    if (stop_det) n_stop++;
    if (!m_oe && sda_bus === 1'b0) n_drive++;
  end

  task automatic q_wait;
    #250;
  endtask

  task automatic m_start;
    m_oe = 1'b0; q_wait;
    scl_m = 1'b1; q_wait;
    m_oe = 1'b1; q_wait;
    scl_m = 1'b0; q_wait;
  endtask

  task automatic m_stop;
    m_oe = 1'b1; q_wait;
    scl_m = 1'b1; q_wait;
    m_oe = 1'b0; q_wait;
  endtask

  task automatic m_wbit(input logic b);
    m_oe = ~b; q_wait;
    scl_m = 1'b1; q_wait; q_wait;
    scl_m = 1'b0; q_wait;
  endtask

  task automatic m_rbit(output logic b);
    m_oe = 1'b0; q_wait;
    scl_m = 1'b1; q_wait;
    b = sda_bus; q_wait;
    scl_m = 1'b0; q_wait;
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    m_rbit(ack);
  endtask

  task automatic m_rbyte(output logic [7:0] d);
    logic [7:0] t;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(b);
      t[i] = b;
    end
    d = t;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({tx_load, rx_valid, addr_match, rw, busy, stop_det} !== 6'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected 000000", {tx_load, rx_valid, addr_match, rw, busy, stop_det});
    end
    tests++; if (rx_data !== 8'h00) begin
      fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data);
    end
    tests++; if (sda_bus !== 1'b1) begin
      fails++; $display("FAIL reset_sda: got %b expected 1", sda_bus);
    end
    rst_n = 1'b1;
    q_wait;
  endtask

  task automatic test_write;
    int am0 = n_am, rx0 = n_rx, st0 = n_stop;
    logic a1, a2;
    m_start;
    m_wbyte(8'h90, a1);
    tests++; if (busy !== 1'b1) begin
      fails++; $display("FAIL write_busy_mid: got %b expected 1", busy);
    end
    m_wbyte(8'hA5, a2);
    m_stop;
    q_wait;
    tests++; if ({a1, a2} !== 2'b00) begin
      fails++; $display("FAIL write_acks: got %b expected 00", {a1, a2});
    end
    tests++; if (n_am - am0 !== 1) begin
      fails++; $display("FAIL write_addr_match: got %0d expected 1", n_am - am0);
    end
    tests++; if (n_rx - rx0 !== 1 || last_rx !== 8'hA5) begin
      fails++; $display("FAIL write_rx: got %0d pulses data %h expected 1 pulse data a5", n_rx - rx0, last_rx);
    end
    tests++; if (rx_data !== 8'hA5) begin
      fails++; $display("FAIL write_rx_data: got %h expected a5", rx_data);
    end
    tests++; if (n_stop - st0 !== 1 || busy !== 1'b0 || rw !== 1'b0) begin
      fails++; $display("FAIL write_end: got stop %0d busy %b rw %b expected 1 0 0", n_stop - st0, busy, rw);
    end
  endtask

  task automatic test_mismatch;
    int am0 = n_am, rx0 = n_rx, st0 = n_stop, dr0 = n_drive;
    logic a1, a2;
    m_start;
    m_wbyte(8'h92, a1);
    m_wbyte(8'hFF, a2);
    m_stop;
    q_wait;
    tests++; if ({a1, a2} !== 2'b11 || n_drive - dr0 !== 0) begin
      fails++; $display("FAIL mismatch_sda: got acks %b drive %0d expected 11 0", {a1, a2}, n_drive - dr0);
    end
    tests++; if (n_am - am0 !== 0 || n_rx - rx0 !== 0) begin
      fails++; $display("FAIL mismatch_pulses: got am %0d rx %0d expected 0 0", n_am - am0, n_rx - rx0);
    end
    tests++; if (n_stop - st0 !== 1) begin
      fails++; $display("FAIL mismatch_stop: got %0d expected 1", n_stop - st0);
    end
  endtask

  task automatic test_read;
    int tx0 = n_tx;
    logic a;
    logic [7:0] d;
    tx_data = 8'h3C;
    m_start;
    m_wbyte(8'h91, a);
    tests++; if (a !== 1'b0 || rw !== 1'b1) begin
      fails++; $display("FAIL read_addr: got ack %b rw %b expected 0 1", a, rw);
    end
    m_rbyte(d);
    m_wbit(1'b1);
    tests++; if (d !== 8'h3C) begin
      fails++; $display("FAIL read_byte: got %h expected 3c", d);
    end
    tests++; if (n_tx - tx0 !== 1 || busy !== 1'b0) begin
      fails++; $display("FAIL read_nack: got tx_load %0d busy %b expected 1 0", n_tx - tx0, busy);
    end
    m_stop;
    q_wait;
  endtask

  task automatic test_read2;
    int tx0 = n_tx;
    logic a;
    logic [7:0] d0, d1;
    tx_data = 8'h12;
    m_start;
    m_wbyte(8'h91, a);
    m_rbyte(d0);
    tx_data = 8'h34;
    m_wbit(1'b0);
    m_rbyte(d1);
    m_wbit(1'b1);
    tests++; if ({d0, d1} !== 16'h1234) begin
      fails++; $display("FAIL read2_bytes: got %h %h expected 12 34", d0, d1);
    end
    tests++; if (n_tx - tx0 !== 2) begin
      fails++; $display("FAIL read2_tx_load: got %0d expected 2", n_tx - tx0);
    end
    tests++; if (sda_bus !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL read2_release: got sda %b busy %b expected 1 0", sda_bus, busy);
    end
    m_stop;
    q_wait;
  endtask

  task automatic test_back_to_back;
    int am0 = n_am, rx0 = n_rx, tx0 = n_tx;
    logic a1, a2, a3;
    logic [7:0] d;
    tx_data = 8'h5A;
    m_start;
    m_wbyte(8'h90, a1);
    m_wbyte(8'h01, a2);
    m_start;
    m_wbyte(8'h91, a3);
    tests++; if (rx_data !== 8'h01 || n_rx - rx0 !== 1) begin
      fails++; $display("FAIL rstart_rx: got %h x%0d expected 01 x1", rx_data, n_rx - rx0);
    end
    tests++; if (n_am - am0 !== 2 || rw !== 1'b1 || {a1, a2, a3} !== 3'b000) begin
      fails++; $display("FAIL rstart_addr: got am %0d rw %b acks %b expected 2 1 000", n_am - am0, rw, {a1, a2, a3});
    end
    m_rbyte(d);
    m_wbit(1'b1);
    tests++; if (d !== 8'h5A || n_tx - tx0 !== 1) begin
      fails++; $display("FAIL rstart_read: got %h x%0d expected 5a x1", d, n_tx - tx0);
    end
    m_stop;
    q_wait;
  endtask

  task automatic test_disable;
    int am0 = n_am, rx0 = n_rx, st0 = n_stop;
    logic a1, a2;
    enable = 1'b0;
    m_start;
    m_wbyte(8'h90, a1);
    m_wbyte(8'h55, a2);
    m_stop;
    q_wait;
    tests++; if ({a1, a2} !== 2'b11 || n_am - am0 !== 0 || n_rx - rx0 !== 0 || n_stop - st0 !== 0) begin
      fails++; $display("FAIL disable: got acks %b am %0d rx %0d stop %0d expected 11 0 0 0", {a1, a2}, n_am - am0, n_rx - rx0, n_stop - st0);
    end
    enable = 1'b1;
    q_wait;
  endtask

  task automatic test_reset_mid;
    logic a1, a2;
    m_start;
    for (int i = 7; i >= 0; i--) m_wbit(logic'((8'h90 >> i) & 8'h01));
    m_oe = 1'b0; q_wait;
    scl_m = 1'b1; q_wait;
    tests++; if (sda_bus !== 1'b0) begin
      fails++; $display("FAIL rstmid_ack_low: got %b expected 0", sda_bus);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (sda_bus !== 1'b1 || {tx_load, rx_valid, addr_match, rw, busy, stop_det} !== 6'b0) begin
      fails++; $display("FAIL rstmid_release: got sda %b outs %b expected 1 000000", sda_bus, {tx_load, rx_valid, addr_match, rw, busy, stop_det});
    end
    rst_n = 1'b1;
    q_wait;
    scl_m = 1'b0; q_wait;
    m_stop;
    m_start;
    m_wbyte(8'h90, a1);
    m_wbyte(8'h77, a2);
    m_stop;
    q_wait;
    tests++; if ({a1, a2} !== 2'b00 || rx_data !== 8'h77) begin
      fails++; $display("FAIL rstmid_recover: got acks %b rx %h expected 00 77", {a1, a2}, rx_data);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write;
    test_mismatch;
    test_read;
    test_read2;
    test_back_to_back;
    test_disable;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
